// File: rtl/ysyx_22050078_lsu_pkg.sv
// Shared LSU operation codes, bus widths and small decode helpers.
package ysyx_22050078_lsu_pkg;

    localparam int LSU_OPT_WIDTH  = 4;
    localparam int MEM_MASK_WIDTH = 8;

    typedef enum logic [LSU_OPT_WIDTH-1:0] {
        LSU_NONE = 4'h0,
        LSU_LB   = 4'h1,
        LSU_LH   = 4'h2,
        LSU_LW   = 4'h3,
        LSU_LD   = 4'h4,
        LSU_LBU  = 4'h5,
        LSU_LHU  = 4'h6,
        LSU_LWU  = 4'h7,
        LSU_SB   = 4'h8,
        LSU_SH   = 4'h9,
        LSU_SW   = 4'hA,
        LSU_SD   = 4'hB
    } lsu_opt_e;

    // log2 of the access size in bytes; non-memory codes report 0
    function automatic logic [1:0] lsu_size(input logic [LSU_OPT_WIDTH-1:0] opt);
        logic [1:0] sz;
        sz = 2'd0;
        case (opt)
            LSU_LH, LSU_LHU, LSU_SH: sz = 2'd1;
            LSU_LW, LSU_LWU, LSU_SW: sz = 2'd2;
            LSU_LD, LSU_SD:          sz = 2'd3;
            default:                 sz = 2'd0;
        endcase
        return sz;
    endfunction

    function automatic logic lsu_is_load(input logic [LSU_OPT_WIDTH-1:0] opt);
        return (opt >= LSU_LB) && (opt <= LSU_LWU);
    endfunction

    function automatic logic lsu_is_store(input logic [LSU_OPT_WIDTH-1:0] opt);
        return (opt >= LSU_SB) && (opt <= LSU_SD);
    endfunction

    function automatic logic lsu_is_signed(input logic [LSU_OPT_WIDTH-1:0] opt);
        return (opt == LSU_LB) || (opt == LSU_LH) || (opt == LSU_LW);
    endfunction

endpackage

// File: rtl/ysyx_22050078_lsu_align.sv
// Combinational data path of the LSU: misalignment check on the incoming op,
// store data/mask formatting and load lane extraction with extension.
module ysyx_22050078_lsu_align
    import ysyx_22050078_lsu_pkg::*;
(
    input  logic [LSU_OPT_WIDTH-1:0]  i_chk_opt,
    input  logic [2:0]                i_chk_off,
    output logic                      o_chk_mem,
    output logic                      o_chk_misalign,
    input  logic [LSU_OPT_WIDTH-1:0]  i_opt,
    input  logic [2:0]                i_off,
    input  logic [63:0]               i_rs2,
    input  logic [63:0]               i_rdata,
    output logic [63:0]               o_wdata,
    output logic [MEM_MASK_WIDTH-1:0] o_wmask,
    output logic [63:0]               o_load_data
);

    logic [1:0]                w_chk_size;
    logic [1:0]                w_size;
    logic                      w_signed;
    logic                      w_store;
    logic [63:0]               w_shifted;
    logic [MEM_MASK_WIDTH-1:0] w_base_mask;
    logic [63:0]               w_rep_data;

    assign w_chk_size = lsu_size(i_chk_opt);
    assign o_chk_mem  = lsu_is_load(i_chk_opt) | lsu_is_store(i_chk_opt);

    always_comb begin
        o_chk_misalign = 1'b0;
        case (w_chk_size)
            2'd1:    o_chk_misalign = i_chk_off[0];
            2'd2:    o_chk_misalign = |i_chk_off[1:0];
            2'd3:    o_chk_misalign = |i_chk_off;
            default: o_chk_misalign = 1'b0;
        endcase
    end

    assign w_size    = lsu_size(i_opt);
    assign w_signed  = lsu_is_signed(i_opt);
    assign w_store   = lsu_is_store(i_opt);
    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        w_rep_data  = '0;
        w_base_mask = '0;
        o_load_data = '0;
        case (w_size)
            2'd0: begin
                w_rep_data  = {8{i_rs2[7:0]}};
                w_base_mask = 8'h01;
                o_load_data = {{56{w_signed & w_shifted[7]}}, w_shifted[7:0]};
            end
            2'd1: begin
                w_rep_data  = {4{i_rs2[15:0]}};
                w_base_mask = 8'h03;
                o_load_data = {{48{w_signed & w_shifted[15]}}, w_shifted[15:0]};
            end
            2'd2: begin
                w_rep_data  = {2{i_rs2[31:0]}};
                w_base_mask = 8'h0F;
                o_load_data = {{32{w_signed & w_shifted[31]}}, w_shifted[31:0]};
            end
            default: begin
                w_rep_data  = i_rs2;
                w_base_mask = 8'hFF;
                o_load_data = w_shifted;
            end
        endcase
    end

    // Loads drive neither write data nor byte enables onto the bus
    assign o_wdata = w_store ? w_rep_data : '0;
    assign o_wmask = w_store ? (w_base_mask << i_off) : '0;

endmodule

// File: rtl/ysyx_22050078_lsu.sv
// Load/store unit between pipe_EX_LS and pipe_LS_WB: one bus transaction per
// memory op, misalignment and response timeout reported as status bits.
//
//   state  | meaning
//   IDLE   | no op held, ready to accept
//   REQ    | o_mem_req high, waiting for i_mem_gnt
//   WAIT   | granted, waiting for i_mem_rvalid or timeout
//   DONE   | result valid, held until i_ready
module ysyx_22050078_lsu
    import ysyx_22050078_lsu_pkg::*;
#(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [63:0]               i_exu_res,
    input  logic [63:0]               i_rs2_data,
    input  logic [LSU_OPT_WIDTH-1:0]  i_lsu_opt,
    input  logic [4:0]                i_rd_idx,
    input  logic                      i_rd_wen,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [63:0]               o_wb_data,
    output logic [4:0]                o_rd_idx,
    output logic                      o_rd_wen,
    output logic                      o_misalign,
    output logic                      o_bus_err,
    output logic                      o_mem_req,
    input  logic                      i_mem_gnt,
    output logic                      o_mem_we,
    output logic [63:0]               o_mem_addr,
    output logic [63:0]               o_mem_wdata,
    output logic [MEM_MASK_WIDTH-1:0] o_mem_wmask,
    input  logic                      i_mem_rvalid,
    input  logic [63:0]               i_mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0] TMO_LAST = 8'(RSP_TIMEOUT - 1);

    logic [1:0]               r_state;
    logic [63:0]              r_addr;
    logic [LSU_OPT_WIDTH-1:0] r_opt;
    logic [63:0]              r_rs2;
    logic [4:0]               r_rd_idx;
    logic                     r_cap_wen;
    logic [63:0]              r_wb_data;
    logic                     r_rd_wen;
    logic                     r_misalign;
    logic                     r_bus_err;
    logic [7:0]               r_cnt;

    logic                      w_accept;
    logic                      w_req;
    logic                      w_chk_mem;
    logic                      w_chk_misalign;
    logic [63:0]               w_wdata;
    logic [MEM_MASK_WIDTH-1:0] w_wmask;
    logic [63:0]               w_load_data;

    ysyx_22050078_lsu_align u_align (
        .i_chk_opt      (i_lsu_opt),
        .i_chk_off      (i_exu_res[2:0]),
        .o_chk_mem      (w_chk_mem),
        .o_chk_misalign (w_chk_misalign),
        .i_opt          (r_opt),
        .i_off          (r_addr[2:0]),
        .i_rs2          (r_rs2),
        .i_rdata        (i_mem_rdata),
        .o_wdata        (w_wdata),
        .o_wmask        (w_wmask),
        .o_load_data    (w_load_data)
    );

    // o_ready is gated by rst_n so nothing is accepted while reset is held
    assign o_ready  = rst_n & ((r_state == S_IDLE) | ((r_state == S_DONE) & i_ready));
    assign w_accept = i_valid & o_ready;
    assign w_req    = (r_state == S_REQ);

    assign o_valid     = (r_state == S_DONE);
    assign o_wb_data   = r_wb_data;
    assign o_rd_idx    = r_rd_idx;
    assign o_rd_wen    = r_rd_wen;
    assign o_misalign  = r_misalign;
    assign o_bus_err   = r_bus_err;

    assign o_mem_req   = w_req;
    assign o_mem_we    = w_req & lsu_is_store(r_opt);
    assign o_mem_addr  = w_req ? {r_addr[63:3], 3'b000} : '0;
    assign o_mem_wdata = w_req ? w_wdata : '0;
    assign o_mem_wmask = w_req ? w_wmask : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_opt      <= '0;
            r_rs2      <= '0;
            r_rd_idx   <= '0;
            r_cap_wen  <= 1'b0;
            r_wb_data  <= '0;
            r_rd_wen   <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_addr     <= i_exu_res;
            r_opt      <= i_lsu_opt;
            r_rs2      <= i_rs2_data;
            r_rd_idx   <= i_rd_idx;
            r_cap_wen  <= i_rd_wen;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            if (!w_chk_mem) begin
                r_state   <= S_DONE;
                r_wb_data <= i_exu_res;
                r_rd_wen  <= i_rd_wen;
            end else if (w_chk_misalign) begin
                r_state    <= S_DONE;
                r_wb_data  <= '0;
                r_rd_wen   <= 1'b0;
                r_misalign <= 1'b1;
            end else begin
                r_state <= S_REQ;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    r_cnt <= '0;
                    if (i_mem_gnt) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_mem_rvalid) begin
                        r_state <= S_DONE;
                        if (lsu_is_store(r_opt)) begin
                            r_wb_data <= '0;
                            r_rd_wen  <= 1'b0;
                        end else begin
                            r_wb_data <= w_load_data;
                            r_rd_wen  <= r_cap_wen;
                        end
                    end else if (r_cnt == TMO_LAST) begin
                        r_state   <= S_DONE;
                        r_wb_data <= '0;
                        r_rd_wen  <= 1'b0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050078_lsu.sv
// Directed bench for the LSU: per-op expectations from a byte-level model,
// checked against the result handshake and the bus request fields.
module tb_ysyx_22050078_lsu;
    import ysyx_22050078_lsu_pkg::*;

    localparam int TMO = 4;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [63:0] i_exu_res = '0;
    logic [63:0] i_rs2_data = '0;
    logic [3:0]  i_lsu_opt = '0;
    logic [4:0]  i_rd_idx = '0;
    logic        i_rd_wen = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [63:0] o_wb_data;
    logic [4:0]  o_rd_idx;
    logic        o_rd_wen;
    logic        o_misalign;
    logic        o_bus_err;
    logic        o_mem_req;
    logic        i_mem_gnt = 1'b0;
    logic        o_mem_we;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    logic        i_mem_rvalid = 1'b0;
    logic [63:0] i_mem_rdata = JUNK;

    ysyx_22050078_lsu #(.RSP_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_exu_res(i_exu_res), .i_rs2_data(i_rs2_data), .i_lsu_opt(i_lsu_opt),
        .i_rd_idx(i_rd_idx), .i_rd_wen(i_rd_wen), .o_valid(o_valid), .i_ready(i_ready),
        .o_wb_data(o_wb_data), .o_rd_idx(o_rd_idx), .o_rd_wen(o_rd_wen),
        .o_misalign(o_misalign), .o_bus_err(o_bus_err), .o_mem_req(o_mem_req),
        .i_mem_gnt(i_mem_gnt), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] wb;
        bit          wb_care;
        logic [4:0]  rd_idx;
        bit          wen;
        bit          mis;
        bit          err;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t ce;

    bit          eb_active = 1'b0;
    logic [63:0] eb_addr, eb_wdata;
    logic [7:0]  eb_wmask;
    bit          eb_we;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic int sz_of(input logic [3:0] opt);
        case (opt)
            LSU_LB, LSU_LBU, LSU_SB: return 1;
            LSU_LH, LSU_LHU, LSU_SH: return 2;
            LSU_LW, LSU_LWU, LSU_SW: return 4;
            LSU_LD, LSU_SD:          return 8;
            default:                 return 0;
        endcase
    endfunction

    function automatic exp_t model_res(input logic [3:0] opt, input logic [63:0] addr,
                                       input logic [4:0] rd, input bit wen,
                                       input logic [63:0] rdata, input bit tmo);
        exp_t e;
        int sz, off;
        logic [63:0] v;
        sz = sz_of(opt);
        off = int'(addr[2:0]);
        e.rd_idx = rd; e.wb_care = 1; e.mis = 0; e.err = 0; e.due = 0;
        e.wb = '0; e.wen = 0;
        if (sz == 0) begin
            e.wb = addr; e.wen = wen;
        end else if (off % sz != 0) begin
            e.mis = 1; e.wb_care = 0;
        end else if (tmo) begin
            e.err = 1; e.wb_care = 0;
        end else if (opt >= LSU_SB) begin
            e.wb = '0;
        end else begin
            v = '0;
            for (int b = 0; b < sz; b++) v[8*b +: 8] = rdata[8*(off+b) +: 8];
            if ((opt == LSU_LB || opt == LSU_LH || opt == LSU_LW) && v[8*sz-1])
                for (int b = sz; b < 8; b++) v[8*b +: 8] = 8'hFF;
            e.wb = v; e.wen = wen;
        end
        return e;
    endfunction

    task automatic model_bus(input logic [3:0] opt, input logic [63:0] addr, input logic [63:0] rs2,
                             output logic [63:0] baddr, output logic [63:0] wdata,
                             output logic [7:0] wmask, output bit we);
        int sz, off;
        sz = sz_of(opt);
        off = int'(addr[2:0]);
        baddr = addr & ~64'h7;
        we = (opt >= LSU_SB);
        wdata = '0;
        wmask = '0;
        for (int b = 0; b < 8; b++) wdata[8*b +: 8] = rs2[8*(b % sz) +: 8];
        for (int b = 0; b < sz; b++) wmask[off+b] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) fail_now("spurious_valid");
                else begin
                    ce = exp_q.pop_front();
                    chk("hs_cycle", 64'(cyc), 64'(ce.due));
                    if (ce.wb_care) chk("wb_data", o_wb_data, ce.wb);
                    chk("rd_idx", 64'(o_rd_idx), 64'(ce.rd_idx));
                    chk("rd_wen", 64'(o_rd_wen), 64'(ce.wen));
                    chk("misalign", 64'(o_misalign), 64'(ce.mis));
                    chk("bus_err", 64'(o_bus_err), 64'(ce.err));
                end
            end
            if (o_mem_req) begin
                if (!eb_active) fail_now("spurious_req");
                else begin
                    chk("mem_addr", o_mem_addr, eb_addr);
                    chk("mem_we", 64'(o_mem_we), 64'(eb_we));
                    if (eb_we) begin
                        chk("mem_wdata", o_mem_wdata, eb_wdata);
                        chk("mem_wmask", 64'(o_mem_wmask), 64'(eb_wmask));
                    end
                end
            end
        end
    end

    // rsp_wait < 0 means the response never comes; stall = cycles i_ready is held low in DONE
    task automatic issue_op(input logic [3:0] opt, input logic [63:0] addr, input logic [63:0] rs2,
                            input logic [4:0] rd, input bit wen, input logic [63:0] rdata,
                            input int gnt_wait, input int rsp_wait, input int stall);
        int a, sz, due;
        bit mem, mis, acc;
        exp_t e;
        logic [63:0] s_wb;
        logic [4:0]  s_idx;
        logic        s_wen;
        @(posedge clk); #1;
        i_valid = 1; i_lsu_opt = opt; i_exu_res = addr; i_rs2_data = rs2;
        i_rd_idx = rd; i_rd_wen = wen; i_ready = (stall == 0);
        acc = 0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk); acc = o_ready;
            @(posedge clk); #1;
        end
        i_valid = 0;
        if (!acc) begin fail_now("accept_timeout"); return; end
        a = cyc;
        sz = sz_of(opt);
        mem = (sz > 0);
        mis = mem && (int'(addr[2:0]) % sz != 0);
        if (!mem || mis) due = a;
        else if (rsp_wait < 0) due = a + 1 + gnt_wait + TMO;
        else due = a + 2 + gnt_wait + rsp_wait;
        due += stall;
        e = model_res(opt, addr, rd, wen, rdata, rsp_wait < 0);
        e.due = due;
        exp_q.push_back(e);
        if (mem && !mis) begin
            model_bus(opt, addr, rs2, eb_addr, eb_wdata, eb_wmask, eb_we);
            eb_active = 1;
            i_mem_gnt = (gnt_wait == 0);
            @(negedge clk);
            chk("req_at_n1", 64'(o_mem_req), 64'd1);
            for (int g = 0; g < gnt_wait; g++) begin @(posedge clk); #1; end
            i_mem_gnt = 1;
            // a response alongside the grant must not be consumed
            i_mem_rvalid = (rsp_wait != 0);
            @(posedge clk); #1;
            i_mem_gnt = 0; i_mem_rvalid = 0; eb_active = 0;
            if (rsp_wait >= 0) begin
                for (int r = 0; r < rsp_wait; r++) begin @(posedge clk); #1; end
                i_mem_rvalid = 1; i_mem_rdata = rdata;
                @(posedge clk); #1;
                i_mem_rvalid = 0; i_mem_rdata = JUNK;
            end
        end
        if (stall > 0) begin
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (o_valid) break;
            end
            if (!o_valid) fail_now("stall_no_valid");
            s_wb = o_wb_data; s_idx = o_rd_idx; s_wen = o_rd_wen;
            for (int s = 0; s < stall - 1; s++) begin
                @(negedge clk);
                chk("stall_valid", 64'(o_valid), 64'd1);
                chk("stall_wb", o_wb_data, s_wb);
                chk("stall_idx", 64'(o_rd_idx), 64'(s_idx));
                chk("stall_wen", 64'(o_rd_wen), 64'(s_wen));
            end
            @(posedge clk); #1;
            i_ready = 1;
        end
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin fail_now("no_result"); exp_q.delete(); end
        i_ready = 1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(o_ready), 64'd0);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_req"}, 64'(o_mem_req), 64'd0);
        chk({tag, "_we"}, 64'(o_mem_we), 64'd0);
        chk({tag, "_mis"}, 64'(o_misalign), 64'd0);
        chk({tag, "_err"}, 64'(o_bus_err), 64'd0);
        chk({tag, "_wen"}, 64'(o_rd_wen), 64'd0);
        chk({tag, "_wb"}, o_wb_data, 64'd0);
        chk({tag, "_idx"}, 64'(o_rd_idx), 64'd0);
        chk({tag, "_addr"}, o_mem_addr, 64'd0);
        chk({tag, "_wdata"}, o_mem_wdata, 64'd0);
        chk({tag, "_wmask"}, 64'(o_mem_wmask), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t pe;
        logic [63:0] pa, pw;
        logic [7:0]  pm;
        bit          pwe;

        // the model itself, pinned against hand-computed values
        pe = model_res(LSU_LB, 64'h8000_0005, 5'd1, 1, 64'h00AB_8000_0000_0000, 0);
        chk("pin_lb", pe.wb, 64'hFFFF_FFFF_FFFF_FF80);
        pe = model_res(LSU_LBU, 64'h8000_0005, 5'd1, 1, 64'h00AB_8000_0000_0000, 0);
        chk("pin_lbu", pe.wb, 64'h80);
        model_bus(LSU_SH, 64'h1002, 64'hBEEF, pa, pw, pm, pwe);
        chk("pin_sh_addr", pa, 64'h1000);
        chk("pin_sh_wdata", pw, 64'hBEEF_BEEF_BEEF_BEEF);
        chk("pin_sh_wmask", 64'(pm), 64'h0C);
        pe = model_res(LSU_LW, 64'h1002, 5'd3, 1, JUNK, 0);
        chk("pin_lw_mis", 64'(pe.mis), 64'd1);

        #12;
        chk_all_zero("reset");
        @(negedge clk); rst_n = 1;

        issue_op(LSU_NONE, 64'h1234, '0, 5'd5, 1, JUNK, 0, 0, 0);
        issue_op(LSU_LB, 64'h8000_0005, '0, 5'd6, 1, 64'h00AB_8000_0000_0000, 0, 0, 0);
        issue_op(LSU_LBU, 64'h8000_0005, '0, 5'd7, 1, 64'h00AB_8000_0000_0000, 0, 0, 0);
        issue_op(LSU_SH, 64'h1002, 64'hBEEF, 5'd8, 1, JUNK, 0, 0, 0);
        issue_op(LSU_SH, 64'h1002, 64'hBEEF, 5'd8, 1, JUNK, 2, 1, 0);
        issue_op(LSU_LW, 64'h1002, '0, 5'd9, 1, JUNK, 0, 0, 0);
        issue_op(LSU_LD, 64'h3008, '0, 5'd10, 1, 64'h8877_6655_4433_2211, 0, 1, 0);
        issue_op(LSU_LW, 64'h3004, '0, 5'd11, 1, 64'h9ABC_DEF0_1234_5678, 1, 0, 0);
        issue_op(LSU_LWU, 64'h3004, '0, 5'd11, 1, 64'h9ABC_DEF0_1234_5678, 0, 0, 0);
        issue_op(LSU_LHU, 64'h3006, '0, 5'd12, 1, 64'hF00D_0000_0000_0000, 0, 2, 0);
        issue_op(LSU_LH, 64'h3006, '0, 5'd12, 0, 64'hF00D_0000_0000_0000, 0, 0, 0);
        issue_op(LSU_SD, 64'h3010, 64'h0123_4567_89AB_CDEF, 5'd13, 1, JUNK, 0, 0, 0);
        issue_op(LSU_SW, 64'h3014, 64'hAAAA_BBBB_CCCC_DDDD, 5'd14, 1, JUNK, 1, 0, 0);
        issue_op(LSU_SB, 64'h3017, 64'h0000_0000_0000_005A, 5'd15, 1, JUNK, 0, 0, 0);
        issue_op(LSU_SD, 64'h3014, 64'h1, 5'd16, 1, JUNK, 0, 0, 0);
        issue_op(LSU_LH, 64'h3001, '0, 5'd17, 1, JUNK, 0, 0, 0);

        // timeout, then a stray response in IDLE
        issue_op(LSU_LD, 64'h4000, '0, 5'd18, 1, JUNK, 0, -1, 0);
        @(posedge clk); #1;
        i_mem_rvalid = 1; i_mem_rdata = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        i_mem_rvalid = 0; i_mem_rdata = JUNK;
        @(negedge clk);
        chk("stray_valid", 64'(o_valid), 64'd0);
        chk("stray_req", 64'(o_mem_req), 64'd0);
        @(negedge clk);
        chk("stray_valid2", 64'(o_valid), 64'd0);

        issue_op(LSU_LH, 64'h5002, '0, 5'd19, 1, 64'h0000_0000_8001_0000, 0, 0, 3);

        // back-to-back non-memory ops, one per cycle
        @(posedge clk); #1;
        i_ready = 1;
        for (int i = 0; i < 4; i++) begin
            exp_t be;
            i_valid = 1; i_lsu_opt = LSU_NONE; i_exu_res = 64'h100 + 64'(i);
            i_rd_idx = 5'(i + 20); i_rd_wen = 1;
            @(posedge clk); #1;
            be = model_res(LSU_NONE, 64'h100 + 64'(i), 5'(i + 20), 1, JUNK, 0);
            be.due = cyc;
            exp_q.push_back(be);
        end
        i_valid = 0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin fail_now("b2b_no_result"); exp_q.delete(); end

        // reset pulse while an LD sits in WAIT
        @(posedge clk); #1;
        i_valid = 1; i_lsu_opt = LSU_LD; i_exu_res = 64'h2000; i_rd_idx = 5'd30; i_rd_wen = 1;
        model_bus(LSU_LD, 64'h2000, '0, eb_addr, eb_wdata, eb_wmask, eb_we);
        @(posedge clk); #1;
        i_valid = 0; i_mem_gnt = 1; eb_active = 1;
        @(posedge clk); #1;
        i_mem_gnt = 0; eb_active = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk_all_zero("rst_wait");
        @(negedge clk); rst_n = 1;
        issue_op(LSU_LD, 64'h2008, '0, 5'd31, 1, 64'hCAFE_F00D_1234_5678, 0, 0, 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050078_lsu.md
# ysyx_22050078_lsu

Load/store unit that consumes the EX-stage result, latched by pipe_EX_LS, and produces the write-back value for pipe_LS_WB. For memory ops, `i_exu_res` is the effective address; the unit runs a request/response transaction on an 8-byte data bus, aligns and extends load data, and formats store data and mask. Non-memory ops pass `i_exu_res` through. Misaligned accesses and bus timeouts are flagged, not trapped.

## Interface
- `RSP_TIMEOUT`, 255: max cycles waited in WAIT for `i_mem_rvalid` before bus error; 1..255.
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `i_valid`  in  1  op valid from pipe_EX_LS
- `o_ready`  out  1  op accepted when `i_valid & o_ready`
- `i_exu_res`  in  64  ALU result / effective address
- `i_rs2_data`  in  64  store data
- `i_lsu_opt`  in  4  `LSU_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD`
- `i_rd_idx`  in  5; `i_rd_wen`  in  1  destination, carried through
- `o_valid`  out  1; `i_ready`  in  1  result handshake to pipe_LS_WB
- `o_wb_data`  out  64; `o_rd_idx`  out  5; `o_rd_wen`  out  1
- `o_misalign`  out  1; `o_bus_err`  out  1  status, valid with `o_valid`
- `o_mem_req`  out  1; `i_mem_gnt`  in  1  request handshake
- `o_mem_we`  out  1; `o_mem_addr`  out  64 (`{addr[63:3],3'b0}`); `o_mem_wdata`  out  64; `o_mem_wmask`  out  8
- `i_mem_rvalid`  in  1; `i_mem_rdata`  in  64  response / write ack

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- `o_ready` = IDLE | (DONE & `i_ready`). The combinational path `i_ready` → `o_ready` is intentional.
- **Accept:** capture addr, opt, rs2, rd.
  - `LSU_NONE` → DONE, with `o_wb_data = i_exu_res`.
  - Misaligned → DONE, with `o_misalign = 1`, `o_rd_wen = 0`, and no bus activity.
    - Misaligned means: H and `addr[0]`; W and `addr[1:0] != 0`; D and `addr[2:0] != 0`.
  - Otherwise → REQ.
- **REQ:** `o_mem_req = 1`, with addr/we/wdata/wmask held stable until `i_mem_gnt`, then → WAIT. Timeout counter is cleared.
- **WAIT:** counter increments each cycle.
  - `i_mem_rvalid` → DONE.
    - Load: `o_wb_data` = `(i_mem_rdata >> 8*addr[2:0])`, truncated to size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU/LD).
    - Store: `o_rd_wen = 0`, `o_wb_data = 0`.
  - Counter reaches `RSP_TIMEOUT` without rvalid → DONE, with `o_bus_err = 1` and `o_rd_wen = 0`.
- **Store formatting:**
  - wdata = rs2 size-field replicated across 64 bits.
  - wmask = `8'h01 / 8'h03 / 8'h0F / 8'hFF` `<< addr[2:0]` for SB/SH/SW/SD.
- **DONE:** `o_valid = 1` with outputs held until `i_ready`.
  - `i_ready` alone → IDLE.
  - `i_ready & i_valid` → accept the new op in the same cycle.
- `i_mem_rvalid` outside WAIT is ignored. This covers stale responses after reset.

## Timing
- Reset (`rst_n` low, async):
  - State = IDLE.
  - `o_ready`, `o_valid`, `o_mem_req`, `o_mem_we`, `o_misalign`, `o_bus_err`, and `o_rd_wen` = 0.
  - All data outputs = 0.
  - `o_ready` is forced to 0 while `rst_n` is low.
- Non-memory or misaligned op: accepted at cycle N, `o_valid` at N+1.
- Load or store with gnt at the first REQ cycle and rvalid at the first WAIT cycle:
  - Accepted at N.
  - `o_mem_req` at N+1.
  - WAIT at N+2.
  - `o_valid` at N+3.
- Back-to-back with `i_ready` held high: one non-memory op per cycle; memory ops are limited by bus latency.
- `i_mem_rvalid` is only sampled in WAIT, so it is never consumed in the gnt cycle.
- Reset asserted in REQ/WAIT/DONE drops to IDLE immediately. `o_mem_req` falls combinationally and the in-flight op is discarded.
- Timeout: `o_bus_err` is asserted at cycle (WAIT entry + `RSP_TIMEOUT`).

## Structure
- Add to `defines.v`:
  - `LSU_OPT_WIDTH` (4) and the twelve `LSU_*` codes, with `LSU_NONE = 4'h0`.
  - `MEM_MASK_WIDTH` (8).
- Sub-module `ysyx_22050078_lsu_align`: purely combinational. It handles store wdata/wmask formatting, load extraction/extension, and misalignment detection.
- The parent holds the FSM, the timeout counter, and the capture/output registers.

## Test plan
- `LSU_NONE`, `i_exu_res = 64'h1234`, `i_rd_wen = 1`, `i_ready = 1` → `o_valid` next cycle, `o_wb_data = 64'h1234`, no `o_mem_req`.
- LB at addr `0x8000_0005`, rdata `64'h00AB_8000_0000_0000` → wmask unused, `o_wb_data = 64'hFFFF_FFFF_FFFF_FF80`. LBU on the same access → `64'h80`.
- SH at addr `0x1002`, rs2 `0xBEEF` → `o_mem_we = 1`, `o_mem_addr = 0x1000`, `o_mem_wmask = 8'h0C`, `o_mem_wdata = 64'hBEEF_BEEF_BEEF_BEEF`, `o_rd_wen = 0`.
- LW at addr `0x1002` → `o_misalign = 1` at N+1, no `o_mem_req`, `o_rd_wen = 0`.
- `RSP_TIMEOUT = 4`, LD granted but no rvalid → `o_bus_err = 1` exactly 4 cycles after WAIT entry; a later stray rvalid in IDLE is ignored.
- `i_ready` low for 3 cycles in DONE → outputs stable. Then `rst_n` pulse during WAIT → all outputs 0, and the next LD completes normally.
